// File: rtl/mmuart_pkg.sv
// Shared definitions for the mmuart receive and transmit stages.
package mmuart_pkg;

    // Oversampling ratio of the enable16 tick against the bit time.
    localparam int OVERSAMPLE = 16;
    // Tick count (from the start edge) that lands in the middle of the start bit.
    localparam int MID_START  = 7;
    // Payload width of an 8N1 frame.
    localparam int DATA_BITS  = 8;

    // Counter compare values derived from the constants above.
    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] CNT_MID  = 4'(MID_START);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    // Receiver frame states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/mmuart_sync.sv
// N-flop synchroniser for an asynchronous single-bit input.
// STAGES must be at least 2.
module mmuart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; reset loads the idle level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mmuart_rx.sv
// mmuart receive stage: 16x oversampled 8N1 deserialiser with framing-error flag.
module mmuart_rx
    import mmuart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       enable16,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    logic       rx_s;
    logic       rx_prev_q;
    logic       start_edge;

    rx_state_t  state_q, state_d;
    logic       busy_q;

    logic [3:0] cnt16_q, cnt16_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_done_q, rx_done_d;
    logic       rx_ferr_q, rx_ferr_d;

    mmuart_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (uart_rx),
        .q_o   (rx_s)
    );

    // A frame only starts on a high-to-low transition seen across two ticks,
    // so a line stuck low (break) never retriggers.
    assign start_edge = rx_prev_q & ~rx_s;

    // State register; busy is registered alongside so it tracks the state exactly.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state decode; the FSM only advances on enable16 ticks.
    always_comb begin
        state_d = state_q;
        if (enable16) begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt16_q == CNT_MID) begin
                        // Line back high at mid start bit: treat as a glitch.
                        state_d = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt16_q == CNT_LAST && bitcnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit leaves room to catch a
                    // back-to-back start edge.
                    if (cnt16_q == CNT_LAST) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter, shift register and result decode for each state.
    always_comb begin
        cnt16_d   = cnt16_q;
        bitcnt_d  = bitcnt_q;
        sh_d      = sh_q;
        rx_data_d = rx_data_q;
        rx_done_d = 1'b0;
        rx_ferr_d = 1'b0;
        if (enable16) begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        cnt16_d = '0;
                    end
                end
                START: begin
                    if (cnt16_q == CNT_MID) begin
                        cnt16_d  = '0;
                        bitcnt_d = '0;
                    end else begin
                        cnt16_d = cnt16_q + 4'd1;
                    end
                end
                DATA: begin
                    // Counter wraps 15->0, so samples fall 16 ticks apart.
                    cnt16_d = cnt16_q + 4'd1;
                    if (cnt16_q == CNT_LAST) begin
                        sh_d     = {rx_s, sh_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                STOP: begin
                    cnt16_d = cnt16_q + 4'd1;
                    if (cnt16_q == CNT_LAST) begin
                        if (rx_s) begin
                            rx_data_d = sh_q;
                            rx_done_d = 1'b1;
                        end else begin
                            // Bad stop bit: drop the byte, keep the last good one.
                            rx_ferr_d = 1'b1;
                        end
                    end
                end
                default: begin
                    cnt16_d = '0;
                end
            endcase
        end
    end

    // Datapath registers; rx_prev follows rx_s on every tick in every state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt16_q   <= '0;
            bitcnt_q  <= '0;
            sh_q      <= '0;
            rx_data_q <= '0;
            rx_done_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            rx_prev_q <= 1'b1;
        end else begin
            cnt16_q   <= cnt16_d;
            bitcnt_q  <= bitcnt_d;
            sh_q      <= sh_d;
            rx_data_q <= rx_data_d;
            rx_done_q <= rx_done_d;
            rx_ferr_q <= rx_ferr_d;
            if (enable16) begin
                rx_prev_q <= rx_s;
            end
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_done      = rx_done_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_mmuart_rx.sv
// Self-checking bench for mmuart_rx: directed scenarios plus randomized frames,
// checked against a frame-timing reference model evaluated over the recorded run.
module tb_mmuart_rx;

    localparam int S    = 2;
    localparam int MAXC = 32768;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       enable16;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_busy;

    mmuart_rx #(.SYNC_STAGES(S)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .enable16     (enable16),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial forever #5 sys_clk = ~sys_clk;

    // Recorded run: in_*[c] are the inputs sampled at posedge c,
    // obs_*[c] are the outputs during the clock period following posedge c.
    logic       in_en   [MAXC];
    logic       in_pin  [MAXC];
    logic       in_rst  [MAXC];
    logic       obs_done[MAXC];
    logic       obs_ferr[MAXC];
    logic       obs_busy[MAXC];
    logic [7:0] obs_data[MAXC];
    int         cyc;

    // Reference model working storage.
    logic       effpin  [MAXC];
    logic       rxs     [MAXC];
    logic       exp_busy[MAXC];
    int         tc      [MAXC];
    logic       tv      [MAXC];
    logic       rb      [MAXC];
    int         rc      [MAXC];
    int         nt;
    int         ed_cyc[$];
    logic [7:0] ed_data[$];
    int         ef_cyc[$];
    logic [7:0] ef_data[$];

    // Observed pulses and intended traffic.
    int         od_cyc[$];
    logic [7:0] od_data[$];
    int         of_cyc[$];
    logic [7:0] want_done[$];
    int         want_ferr;

    int n_checks;
    int n_fail;
    int div;
    int stall_pct;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic pin, input logic rst);
        @(negedge sys_clk);
        obs_done[cyc] = rx_done;
        obs_ferr[cyc] = rx_frame_err;
        obs_busy[cyc] = rx_busy;
        obs_data[cyc] = rx_data;
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, MAXC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        cyc++;
        enable16    = en;
        uart_rx     = pin;
        sys_rst     = rst;
        in_en[cyc]  = en;
        in_pin[cyc] = pin;
        in_rst[cyc] = rst;
    endtask

    // Freeze: no ticks, pin wiggles, then settles back to the line level.
    task automatic stall(input logic lvl);
        int n;
        n = int'($urandom_range(4, 12));
        for (int k = 0; k < n; k++) begin
            step(1'b0, (k < n - 3) ? 1'($urandom_range(0, 1)) : lvl, 1'b0);
        end
    endtask

    task automatic tick(input logic lvl);
        if (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct) stall(lvl);
        for (int k = 1; k <= div; k++) step(k == div, lvl, 1'b0);
    endtask

    task automatic ticks(input logic lvl, input int n);
        for (int k = 0; k < n; k++) tick(lvl);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        ticks(1'b0, 16);
        for (int i = 0; i < 8; i++) ticks(b[i], 16);
        ticks(stop, 16);
    endtask

    task automatic mark_busy(input int a, input int b);
        for (int c = a; c <= b; c++) if (c < MAXC) exp_busy[c] = 1'b1;
    endtask

    // Frame model: a start edge at tick t is confirmed at tick t+8, data bit k
    // is taken at tick t+24+16k, the stop bit at tick t+152; results appear in
    // the period after that tick and busy covers [edge tick, end tick).
    task automatic run_model();
        int ncyc, pend, rcyc, i, t, natend, abort_j;
        logic prev;
        logic [7:0] last, b;
        ncyc = cyc;
        for (int c = 0; c <= ncyc; c++) begin
            effpin[c]   = in_pin[c];
            exp_busy[c] = 1'b0;
        end
        // Reset loads the synchroniser with ones, hiding the last S pin samples.
        for (int c = 0; c <= ncyc; c++)
            if (in_rst[c])
                for (int k = 0; k < S; k++) if (c - k >= 0) effpin[c - k] = 1'b1;
        for (int c = 0; c <= ncyc; c++) rxs[c] = (c >= S) ? effpin[c - S] : 1'b1;
        nt = 0; pend = 0; rcyc = 0;
        for (int c = 0; c <= ncyc; c++) begin
            if (in_rst[c]) begin
                if (pend == 0) rcyc = c;
                pend = 1;
            end else if (in_en[c]) begin
                tc[nt] = c; tv[nt] = rxs[c]; rb[nt] = (pend != 0); rc[nt] = rcyc;
                pend = 0;
                nt++;
            end
        end
        prev = 1'b1; last = 8'h00; i = 0;
        while (i < nt) begin
            if (rb[i]) begin prev = 1'b1; last = 8'h00; end
            if (prev && !tv[i]) begin
                t = i;
                natend = (t + 8 < nt && tv[t + 8]) ? t + 8 : t + 152;
                abort_j = -1;
                for (int j = t + 1; j <= natend && j < nt; j++)
                    if (rb[j] && abort_j < 0) abort_j = j;
                if (abort_j >= 0) begin
                    mark_busy(tc[t], rc[abort_j] - 1);
                    i = abort_j;
                end else if (natend >= nt) begin
                    mark_busy(tc[t], ncyc);
                    i = nt;
                end else begin
                    mark_busy(tc[t], tc[natend] - 1);
                    if (natend == t + 8) begin
                        prev = 1'b1;
                        i = t + 9;
                    end else begin
                        for (int k = 0; k < 8; k++) b[k] = tv[t + 24 + 16 * k];
                        if (tv[natend]) begin
                            ed_cyc.push_back(tc[natend]); ed_data.push_back(b); last = b;
                        end else begin
                            ef_cyc.push_back(tc[natend]); ef_data.push_back(last);
                        end
                        prev = tv[natend];
                        i = natend + 1;
                    end
                end
            end else begin
                prev = tv[i];
                i++;
            end
        end
    endtask

    initial begin
        logic [7:0] bv;
        logic       stop;
        int g2_cyc, idx6, nbusy, nboth, nchg, n;

        n_checks = 0; n_fail = 0; want_ferr = 0; cyc = 0;
        div = 4; stall_pct = 0;
        sys_rst = 1'b1; enable16 = 1'b0; uart_rx = 1'b1;
        in_rst[0] = 1'b1; in_en[0] = 1'b0; in_pin[0] = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // 1: single 0xA5 at divisor 4
        ticks(1'b1, 20);
        send_frame(8'hA5, 1'b1); want_done.push_back(8'hA5);
        ticks(1'b1, 20);

        // 2: 4-tick low glitch, then 0x3C
        ticks(1'b0, 4);
        ticks(1'b1, 20);
        g2_cyc = cyc;
        send_frame(8'h3C, 1'b1); want_done.push_back(8'h3C);
        ticks(1'b1, 20);

        // 3: good 0xA5, then 0x55 with a low stop bit
        send_frame(8'hA5, 1'b1); want_done.push_back(8'hA5);
        send_frame(8'h55, 1'b0); want_ferr++;
        ticks(1'b1, 20);

        // 4: break of 40 bit times, one bit high, then 0x00
        ticks(1'b0, 40 * 16); want_ferr++;
        ticks(1'b1, 16);
        send_frame(8'h00, 1'b1); want_done.push_back(8'h00);
        ticks(1'b1, 20);

        // 5: reset during data bit 4 of 0xC3, then 0xFF
        bv = 8'hC3;
        ticks(1'b0, 16);
        for (int i = 0; i < 4; i++) ticks(bv[i], 16);
        ticks(bv[4], 8);
        step(1'b1, 1'b1, 1'b1);
        ticks(1'b1, 20);
        send_frame(8'hFF, 1'b1); want_done.push_back(8'hFF);
        ticks(1'b1, 20);

        // 6: enable16 every cycle, back-to-back 0x01 and 0x80
        div = 1;
        idx6 = want_done.size();
        send_frame(8'h01, 1'b1); want_done.push_back(8'h01);
        send_frame(8'h80, 1'b1); want_done.push_back(8'h80);
        ticks(1'b1, 20);

        // Randomized traffic: divisor, gaps, glitches, stop bits and freezes
        stall_pct = 3;
        for (int f = 0; f < 10; f++) begin
            div = int'($urandom_range(1, 3));
            ticks(1'b1, int'($urandom_range(0, 10)));
            if ($urandom_range(0, 3) == 0) begin
                ticks(1'b0, int'($urandom_range(1, 4)));
                ticks(1'b1, int'($urandom_range(10, 20)));
            end
            bv   = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(bv, stop);
            if (stop) begin
                want_done.push_back(bv);
            end else begin
                want_ferr++;
                ticks(1'b1, 4);
            end
        end
        stall_pct = 0;
        ticks(1'b1, 20);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0);

        run_model();

        // Reset values in the period following every reset cycle
        for (int c = 0; c < cyc; c++) begin
            if (in_rst[c]) begin
                check_eq($sformatf("rst_data@%0d", c), obs_data[c], 8'h00);
                check_eq($sformatf("rst_done@%0d", c), obs_done[c], 1'b0);
                check_eq($sformatf("rst_ferr@%0d", c), obs_ferr[c], 1'b0);
                check_eq($sformatf("rst_busy@%0d", c), obs_busy[c], 1'b0);
            end
        end

        nbusy = 0; nboth = 0; nchg = 0;
        for (int c = 0; c < cyc; c++) begin
            if (obs_done[c] === 1'b1) begin od_cyc.push_back(c); od_data.push_back(obs_data[c]); end
            if (obs_ferr[c] === 1'b1) of_cyc.push_back(c);
            if (obs_done[c] === 1'b1 && obs_ferr[c] === 1'b1) nboth++;
            if (obs_busy[c] !== exp_busy[c]) nbusy++;
            if (c > 0 && !in_rst[c] && obs_done[c] !== 1'b1 && obs_data[c] !== obs_data[c - 1]) nchg++;
        end

        // Against the reference model
        check_eq("model_done_count", od_cyc.size(), ed_cyc.size());
        n = (od_cyc.size() < ed_cyc.size()) ? od_cyc.size() : ed_cyc.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("done%0d_cycle", i), od_cyc[i], ed_cyc[i]);
            check_eq($sformatf("done%0d_data", i), od_data[i], ed_data[i]);
        end
        check_eq("model_ferr_count", of_cyc.size(), ef_cyc.size());
        n = (of_cyc.size() < ef_cyc.size()) ? of_cyc.size() : ef_cyc.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("ferr%0d_cycle", i), of_cyc[i], ef_cyc[i]);
            check_eq($sformatf("ferr%0d_data_hold", i), obs_data[of_cyc[i]], ef_data[i]);
        end
        check_eq("busy_mismatch_cycles", nbusy, 0);
        check_eq("done_and_ferr_same_cycle", nboth, 0);
        check_eq("data_changed_without_done", nchg, 0);

        // Against the intended traffic
        check_eq("intent_done_count", od_data.size(), want_done.size());
        n = (od_data.size() < want_done.size()) ? od_data.size() : want_done.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("intent_byte%0d", i), od_data[i], want_done[i]);
        check_eq("intent_ferr_count", of_cyc.size(), want_ferr);

        // Scenario-specific points
        if (od_cyc.size() > 0) begin
            check_eq("t1_busy_low_at_pulse", obs_busy[od_cyc[0]], 1'b0);
            check_eq("t1_busy_high_before_pulse", obs_busy[od_cyc[0] - 1], 1'b1);
        end else begin
            check_eq("t1_pulse_present", od_cyc.size(), 1);
        end
        check_eq("t2_idle_after_glitch", obs_busy[g2_cyc], 1'b0);
        if (od_cyc.size() > idx6 + 1) begin
            check_eq("t6_pulse_spacing", od_cyc[idx6 + 1] - od_cyc[idx6], 160);
        end else begin
            check_eq("t6_pulses_present", od_cyc.size(), idx6 + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
